uart_rx_buffered: RTL and testbench
===================================

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, legal 8..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of 2, legal 2..256).
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only under UART_RX_PARITY_EN.
REQ-005 SHALL have port rxclk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port sample_tick  input  1  one-cycle enable at OVERSAMPLE x baud rate.
REQ-008 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data  output  DATA_BITS  FIFO head byte.
REQ-010 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts head; pop when rx_valid && rx_ready.
REQ-012 SHALL have port rx_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have ports frame_err, parity_err, overrun_err  output  1 each  sticky error flags.
REQ-014 SHALL have port err_clr  input  1  clears all sticky error flags.

Function
REQ-015 SHALL synchronise rx_in through two flops (rx_d1, rx_d2); all decisions use rx_d2.
REQ-016 SHALL implement FSM IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; tick counter and bit counter advance only on sample_tick.
REQ-017 IDLE: on sample_tick with rx_d2==0 -> START, tick counter cleared.
REQ-018 START: at tick OVERSAMPLE/2-1 sample rx_d2; 1 -> IDLE (false start, nothing stored); 0 -> DATA, tick counter cleared.
REQ-019 DATA: sample every OVERSAMPLE ticks, LSB first; after DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-020 PARITY: sample one bit; mismatch marks frame bad-parity; -> STOP.
REQ-021 STOP: sample after OVERSAMPLE ticks; 0 -> set frame_err, discard byte, -> WAIT_IDLE; 1 -> push byte unless bad-parity (then set parity_err, discard), -> IDLE.
REQ-022 WAIT_IDLE: stay until rx_d2==1 on a sample_tick (break never seen as start), -> IDLE.
REQ-023 Push SHALL occur in the cycle of the stop-bit sample; rx_valid/rx_data reflect it the following cycle when FIFO was empty.
REQ-024 FIFO SHALL be first-word-fall-through; rx_data valid whenever rx_valid=1; rx_data undefined-but-stable when empty (holds last head).
REQ-025 Push when full and no pop in same cycle: byte dropped, overrun_err set, FIFO unchanged.
REQ-026 Push and pop same cycle when full: both accepted, rx_count unchanged, no overrun.
REQ-027 Push and pop same cycle at any occupancy: rx_count unchanged; pop on empty ignored.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; rx_count ranges 0..FIFO_DEPTH.
REQ-029 Error flags SHALL stay set until err_clr; err_clr coinciding with a new error leaves that flag set.

Reset
REQ-030 Reset SHALL force FSM IDLE, counters 0, rx_d1=rx_d2=1, FIFO empty, rx_count=0, rx_valid=0, rx_data=0, all error flags 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no push and no error; reception resumes at the next falling edge after reset release.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: frame carries one parity bit after data, checked per PARITY_ODD.
REQ-033 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is start+DATA_BITS+stop, parity_err tied 0, PARITY_ODD ignored.

Verification
REQ-034 Defaults, no parity, 8N1 frame 0x55, rx_ready=0 -> rx_valid=1, rx_data=0x55, rx_count=1, no errors.
REQ-035 rx_in low for 4 ticks then high -> FSM returns IDLE, rx_count=0, no error flags.
REQ-036 Frame 0xA3 with stop bit 0 -> frame_err=1, rx_count=0; line held low 3 bit times then frame 0x12 -> only 0x12 received.
REQ-037 17 frames 0x00..0x10, rx_ready=0 -> rx_count=16, overrun_err=1, head 0x00; then drain -> 0x00..0x0F in order.
REQ-038 UART_RX_PARITY_EN, PARITY_ODD=1, frame 0x01 with parity bit 1 -> parity_err=1, no push; with parity 0 -> 0x01 pushed; err_clr -> parity_err=0.
REQ-039 Reset asserted during data bit 4 of a frame -> all outputs at reset values, no push; next full frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if: receive FIFO head/handshake bundle between the UART receiver and its consumer
interface uart_rx_buffered_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic [$clog2(FIFO_DEPTH):0] rx_count;
  modport master(output rx_data, rx_valid, rx_count, input rx_ready);
  modport slave(input rx_data, rx_valid, rx_count, output rx_ready);
endinterface

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampled UART receiver into a first-word-fall-through FIFO with sticky errors
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (sense set by PARITY_ODD).
module uart_rx_buffered #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic rxclk,
  input  logic reset,
  input  logic sample_tick,
  input  logic rx_in,
  input  logic err_clr,
  output logic frame_err,
  output logic parity_err,
  output logic overrun_err,
  uart_rx_buffered_if.master rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_IDLE
  } state_t;
  state_t state;
  logic rx_d1, rx_d2;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count, count_nxt;
  logic bad, bit_end, start_mid, stop_end, push, pop, full, wr_en;
  assign bit_end = sample_tick && tick_cnt == FULL;
  assign start_mid = state == START && tick_cnt == HALF;
  assign stop_end = bit_end && state == STOP;
  assign push = stop_end && rx_d2 && !bad;
  assign pop = count != '0 && rx.rx_ready;
  assign full = count == CW'(FIFO_DEPTH);
  assign wr_en = push && (!full || pop);
  assign rd_nxt = rd_ptr + AW'(pop);
  assign count_nxt = count + CW'(wr_en) - CW'(pop);
  assign rx.rx_valid = count != '0;
  assign rx.rx_count = count;
  always_ff @(posedge rxclk) begin
    if (reset) begin
      state <= IDLE;
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      bad <= 1'b0;
`endif
    end else begin
      rx_d1 <= rx_in;
      rx_d2 <= rx_d1;
      if (sample_tick) begin
        tick_cnt <= (state == IDLE || bit_end || start_mid) ? '0 : tick_cnt + 1'b1;
        case (state)
          IDLE: if (!rx_d2) state <= START;
          START: if (start_mid) state <= rx_d2 ? IDLE : DATA;
          DATA: if (bit_end) begin
            shreg <= {rx_d2, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == LAST) state <= PARITY;
`else
            if (bit_cnt == LAST) state <= STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
          PARITY: if (bit_end) begin
            bad <= rx_d2 ^ (^shreg) ^ (PARITY_ODD != 0);
            state <= STOP;
          end
`endif
          STOP: if (bit_end) state <= rx_d2 ? IDLE : WAIT_IDLE;
          WAIT_IDLE: if (rx_d2) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifndef UART_RX_PARITY_EN
  assign bad = 1'b0;
  assign parity_err = 1'b0 && PARITY_ODD != 0;
`endif
  // a new error in the same cycle as err_clr wins
  always_ff @(posedge rxclk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= (stop_end && !rx_d2) || (frame_err && !err_clr);
      overrun_err <= (push && full && !pop) || (overrun_err && !err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err <= (stop_end && rx_d2 && bad) || (parity_err && !err_clr);
`endif
    end
  end
  always_ff @(posedge rxclk) if (wr_en) mem[wr_ptr] <= shreg;
  // head register: the freshly pushed byte bypasses the memory when it lands at the new read slot
  always_ff @(posedge rxclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rx.rx_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_nxt;
      count <= count_nxt;
      if (count_nxt != '0) rx.rx_data <= (wr_en && wr_ptr == rd_nxt) ? shreg : mem[rd_nxt];
    end
  end
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed and randomized frames against a queue model of the receive FIFO
module tb_uart_rx_buffered;
  localparam int DB = 8;
  localparam int OVS = 16;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
  localparam int PODD = 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int PODD = 0;
  localparam bit PAR_EN = 1'b0;
`endif
  logic rxclk = 1'b0, reset = 1'b1, sample_tick = 1'b0, rx_in = 1'b1, err_clr = 1'b0;
  logic frame_err, parity_err, overrun_err;
  int vectors = 0, miscompares = 0;
  logic [DB-1:0] q[$];
  bit exp_frame, exp_par, exp_ovr, pop_win;
  uart_rx_buffered_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) rx();
  uart_rx_buffered #(.DATA_BITS(DB), .OVERSAMPLE(OVS), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)) dut (
    .rxclk(rxclk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_in), .err_clr(err_clr),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err), .rx(rx)
  );
  always #5 rxclk = ~rxclk;
  initial forever begin
    @(negedge rxclk);
    sample_tick = ~sample_tick;
  end
  task automatic wait_bits(input int n);
    repeat (n * OVS * 2) @(negedge rxclk);
  endtask
  // drives one frame and updates the model at the start of the stop bit
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_bit, input bit par_flip);
    bit bad_par;
    bad_par = PAR_EN && par_flip;
    rx_in = 1'b0;
    wait_bits(1);
    for (int i = 0; i < DB; i++) begin
      pop_win = i >= 1 && i <= DB - 2;
      rx_in = d[i];
      wait_bits(1);
    end
    pop_win = 1'b0;
    if (PAR_EN) begin
      rx_in = (^d) ^ (PODD != 0) ^ par_flip;
      wait_bits(1);
    end
    if (!stop_bit) exp_frame = 1'b1;
    else if (bad_par) exp_par = 1'b1;
    else if (q.size() == DEPTH) exp_ovr = 1'b1;
    else q.push_back(d);
    rx_in = stop_bit;
    wait_bits(1);
    rx_in = 1'b1;
  endtask
  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge rxclk);
    err_clr = 1'b0;
    {exp_frame, exp_par, exp_ovr} = 3'b000;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge rxclk);
    vectors++; if (rx.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", rx.rx_valid); end
    vectors++; if (rx.rx_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", rx.rx_count); end
    vectors++; if (rx.rx_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 00", rx.rx_data); end
    vectors++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {frame_err, parity_err, overrun_err}); end
    reset = 1'b0;
    wait_bits(1);
  endtask
  task automatic test_single();
    send_frame(8'h55, 1'b1, 1'b0);
    vectors++; if (rx.rx_valid !== 1'b1 || rx.rx_data !== 8'h55) begin miscompares++; $display("FAIL single_head: got valid=%b data=%h want 1/55", rx.rx_valid, rx.rx_data); end
    vectors++; if (rx.rx_count !== CW'(1)) begin miscompares++; $display("FAIL single_count: got %0d want 1", rx.rx_count); end
    vectors++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin miscompares++; $display("FAIL single_flags: got %b want 000", {frame_err, parity_err, overrun_err}); end
    rx.rx_ready = 1'b1;
    @(negedge rxclk);
    rx.rx_ready = 1'b0;
    q.delete();
    vectors++; if (rx.rx_valid !== 1'b0 || rx.rx_count !== '0) begin miscompares++; $display("FAIL single_pop: got valid=%b count=%0d want 0/0", rx.rx_valid, rx.rx_count); end
    rx.rx_ready = 1'b1;
    @(negedge rxclk);
    rx.rx_ready = 1'b0;
    vectors++; if (rx.rx_count !== '0 || rx.rx_data !== 8'h55) begin miscompares++; $display("FAIL empty_pop: got count=%0d data=%h want 0/55", rx.rx_count, rx.rx_data); end
  endtask
  task automatic test_false_start();
    rx_in = 1'b0;
    repeat (8) @(negedge rxclk);
    rx_in = 1'b1;
    wait_bits(2);
    vectors++; if (rx.rx_count !== '0 || {frame_err, parity_err, overrun_err} !== 3'b000) begin miscompares++; $display("FAIL false_start: got count=%0d flags=%b want 0/000", rx.rx_count, {frame_err, parity_err, overrun_err}); end
  endtask
  task automatic test_frame_err();
    send_frame(8'hA3, 1'b0, 1'b0);
    vectors++; if (frame_err !== exp_frame || rx.rx_count !== '0) begin miscompares++; $display("FAIL frame_err: got flag=%b count=%0d want %b/0", frame_err, rx.rx_count, exp_frame); end
    rx_in = 1'b0;
    wait_bits(3);
    rx_in = 1'b1;
    wait_bits(1);
    send_frame(8'h12, 1'b1, 1'b0);
    vectors++; if (rx.rx_count !== CW'(1) || rx.rx_data !== 8'h12) begin miscompares++; $display("FAIL after_break: got count=%0d data=%h want 1/12", rx.rx_count, rx.rx_data); end
    clear_errors();
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL frame_clr: got %b want 0", frame_err); end
    rx.rx_ready = 1'b1;
    @(negedge rxclk);
    rx.rx_ready = 1'b0;
    q.delete();
  endtask
  task automatic test_overrun();
    for (int i = 0; i <= DEPTH; i++) send_frame(DB'(i), 1'b1, 1'b0);
    vectors++; if (rx.rx_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL ovr_count: got %0d want %0d", rx.rx_count, DEPTH); end
    vectors++; if (overrun_err !== 1'b1 || exp_ovr !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", overrun_err); end
    vectors++; if (rx.rx_data !== 8'h00) begin miscompares++; $display("FAIL ovr_head: got %h want 00", rx.rx_data); end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++; if (rx.rx_valid !== 1'b1 || rx.rx_data !== DB'(i)) begin miscompares++; $display("FAIL drain_%0d: got valid=%b data=%h want 1/%h", i, rx.rx_valid, rx.rx_data, DB'(i)); end
      rx.rx_ready = 1'b1;
      @(negedge rxclk);
      rx.rx_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge rxclk);
    end
    q.delete();
    vectors++; if (rx.rx_count !== '0 || rx.rx_valid !== 1'b0) begin miscompares++; $display("FAIL drain_end: got count=%0d valid=%b want 0/0", rx.rx_count, rx.rx_valid); end
    clear_errors();
    vectors++; if (overrun_err !== 1'b0) begin miscompares++; $display("FAIL ovr_clr: got %b want 0", overrun_err); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b1);
    vectors++; if (parity_err !== 1'b1 || rx.rx_count !== '0) begin miscompares++; $display("FAIL parity_bad: got flag=%b count=%0d want 1/0", parity_err, rx.rx_count); end
    send_frame(8'h01, 1'b1, 1'b0);
    vectors++; if (rx.rx_count !== CW'(1) || rx.rx_data !== 8'h01) begin miscompares++; $display("FAIL parity_good: got count=%0d data=%h want 1/01", rx.rx_count, rx.rx_data); end
    clear_errors();
    vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL parity_clr: got %b want 0", parity_err); end
    rx.rx_ready = 1'b1;
    @(negedge rxclk);
    rx.rx_ready = 1'b0;
    q.delete();
  endtask
`endif
  task automatic test_reset_midframe();
    logic [DB-1:0] d;
    d = 8'hC9;
    send_frame(8'h33, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    rx_in = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      wait_bits(1);
    end
    rx_in = d[4];
    repeat (OVS) @(negedge rxclk);
    reset = 1'b1;
    repeat (3) @(negedge rxclk);
    vectors++; if (rx.rx_count !== '0 || rx.rx_valid !== 1'b0 || rx.rx_data !== '0) begin miscompares++; $display("FAIL mid_reset_fifo: got count=%0d valid=%b data=%h want 0/0/00", rx.rx_count, rx.rx_valid, rx.rx_data); end
    vectors++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin miscompares++; $display("FAIL mid_reset_flags: got %b want 000", {frame_err, parity_err, overrun_err}); end
    rx_in = 1'b1;
    reset = 1'b0;
    q.delete();
    {exp_frame, exp_par, exp_ovr} = 3'b000;
    wait_bits(DB + 2);
    vectors++; if (rx.rx_count !== '0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL mid_reset_tail: got count=%0d frame_err=%b want 0/0", rx.rx_count, frame_err); end
    send_frame(8'h7E, 1'b1, 1'b0);
    vectors++; if (rx.rx_count !== CW'(1) || rx.rx_data !== 8'h7E) begin miscompares++; $display("FAIL after_reset: got count=%0d data=%h want 1/7e", rx.rx_count, rx.rx_data); end
    rx.rx_ready = 1'b1;
    @(negedge rxclk);
    rx.rx_ready = 1'b0;
    q.delete();
  endtask
  task automatic test_streaming();
    bit done;
    done = 1'b0;
    clear_errors();
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          send_frame(DB'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
          repeat ($urandom_range(0, 20)) @(negedge rxclk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge rxclk);
          rx.rx_ready = pop_win && q.size() > 0 && $urandom_range(0, 1) == 1;
          if (rx.rx_ready) begin
            vectors++; if (rx.rx_valid !== 1'b1 || rx.rx_data !== q[0] || rx.rx_count !== CW'(q.size())) begin miscompares++; $display("FAIL stream_pop: got valid=%b data=%h count=%0d want 1/%h/%0d", rx.rx_valid, rx.rx_data, rx.rx_count, q[0], q.size()); end
            void'(q.pop_front());
          end
        end
        rx.rx_ready = 1'b0;
      end
    join
    vectors++; if ({frame_err, parity_err, overrun_err} !== {exp_frame, exp_par, exp_ovr}) begin miscompares++; $display("FAIL stream_flags: got %b want %b", {frame_err, parity_err, overrun_err}, {exp_frame, exp_par, exp_ovr}); end
    while (q.size() > 0) begin
      vectors++; if (rx.rx_valid !== 1'b1 || rx.rx_data !== q[0] || rx.rx_count !== CW'(q.size())) begin miscompares++; $display("FAIL stream_drain: got valid=%b data=%h count=%0d want 1/%h/%0d", rx.rx_valid, rx.rx_data, rx.rx_count, q[0], q.size()); end
      rx.rx_ready = 1'b1;
      @(negedge rxclk);
      rx.rx_ready = 1'b0;
      void'(q.pop_front());
    end
    vectors++; if (rx.rx_count !== '0 || rx.rx_valid !== 1'b0) begin miscompares++; $display("FAIL stream_end: got count=%0d valid=%b want 0/0", rx.rx_count, rx.rx_valid); end
  endtask
  initial begin
    rx.rx_ready = 1'b0;
    pop_win = 1'b0;
    {exp_frame, exp_par, exp_ovr} = 3'b000;
    test_reset();
    test_single();
    test_false_start();
    test_frame_err();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    test_streaming();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
